// File: rtl/imem_loader_if.sv
// Stream-in and byte-write bus for the instruction memory loader.
//   in_word/in_valid/in_ready : 32-bit instruction word stream into the loader
//   mem_we/mem_addr/mem_wdata : byte write port toward the instruction memory
// master = loader side, slave = producer/memory side.
interface imem_loader_if;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (
        input  in_word, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_word, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: takes 32-bit words from a valid/ready stream and
// writes each as four big-endian byte writes ([31:24] at the lowest address).
// Holds the CPU (cpu_hold) while a load is running.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : begin a load (honoured only in IDLE/DONE)
//   base_addr      : byte address of first word, latched on accepted start
//   word_count     : number of words, latched on accepted start
//   bus            : word stream in, byte write port out (imem_loader_if.master)
//   busy/cpu_hold  : load in progress
//   done           : last load completed (level)
//   error          : last start rejected because the load would overrun memory
module imem_loader #(
    parameter int unsigned MEM_BYTES = 144,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    imem_loader_if.master    bus,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    // Wide enough that base_addr + 4*word_count can never wrap.
    localparam int unsigned SUM_W = ((CNT_W + 2 > 32) ? CNT_W + 2 : 32) + 1;

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t           state, state_n;
    logic [31:0]      wr_addr, wr_addr_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic [1:0]       idx, idx_n;
    logic [31:0]      word, word_n;
    logic             done_n, error_n;
    logic             in_ready_n, mem_we_n, busy_n;
    logic [31:0]      mem_addr_n;
    logic [7:0]       mem_wdata_n;
    logic [SUM_W-1:0] end_addr_c;
    logic             overflow_c;

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_n     = state;
        wr_addr_n   = wr_addr;
        remaining_n = remaining;
        idx_n       = idx;
        word_n      = word;
        done_n      = done;
        error_n     = error;
        in_ready_n  = 1'b0;
        mem_we_n    = 1'b0;
        busy_n      = 1'b0;
        mem_addr_n  = 32'd0;
        mem_wdata_n = 8'd0;

        end_addr_c = SUM_W'(base_addr) + (SUM_W'(word_count) << 2);
        overflow_c = end_addr_c > SUM_W'(MEM_BYTES);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    wr_addr_n   = base_addr;
                    remaining_n = word_count;
                    done_n      = 1'b0;
                    error_n     = 1'b0;
                    if (overflow_c) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else if (word_count == CNT_W'(0)) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                // in_ready is registered high in this state, so in_valid alone completes the handshake.
                if (bus.in_valid) begin
                    word_n  = bus.in_word;
                    idx_n   = 2'd0;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                idx_n = idx + 2'd1;
                if (idx == 2'd3) begin
                    wr_addr_n   = wr_addr + 32'd4;
                    remaining_n = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = ACCEPT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        in_ready_n = (state_n == ACCEPT);
        busy_n     = (state_n == ACCEPT) || (state_n == WRITE);
        if (state_n == WRITE) begin
            mem_we_n   = 1'b1;
            mem_addr_n = wr_addr_n + 32'(idx_n);
            case (idx_n)
                2'd0:    mem_wdata_n = word_n[31:24];
                2'd1:    mem_wdata_n = word_n[23:16];
                2'd2:    mem_wdata_n = word_n[15:8];
                default: mem_wdata_n = word_n[7:0];
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_addr       <= 32'd0;
            remaining     <= CNT_W'(0);
            idx           <= 2'd0;
            word          <= 32'd0;
            done          <= 1'b0;
            error         <= 1'b0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 8'd0;
        end else begin
            state         <= state_n;
            wr_addr       <= wr_addr_n;
            remaining     <= remaining_n;
            idx           <= idx_n;
            word          <= word_n;
            done          <= done_n;
            error         <= error_n;
            busy          <= busy_n;
            bus.in_ready  <= in_ready_n;
            bus.mem_we    <= mem_we_n;
            bus.mem_addr  <= mem_addr_n;
            bus.mem_wdata <= mem_wdata_n;
        end
    end

    assign cpu_hold = busy;

endmodule
